// File: rtl/fir_hls_tap_accumulator_if.sv
// Product-in / sample-out stream bundle for the FIR tap accumulator.
// The accumulator takes the slave side; the upstream/downstream driver takes master.
interface fir_hls_tap_accumulator_if #(
    parameter int PROD_W = 23,
    parameter int OUT_W  = 16
);
    logic signed [PROD_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_last;
    logic                     in_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     err_last;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, err_last
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, err_last
    );
endinterface

// File: rtl/fir_hls_tap_accumulator.sv
// Sums NUM_TAPS signed products per sample, rounds half-up, shifts out FRAC_SHIFT bits.
// Define FIR_HLS_ACC_SATURATE_EN to clamp to OUT_W; otherwise the result wraps.
module fir_hls_tap_accumulator #(
    parameter int PROD_W     = 23,
    parameter int NUM_TAPS   = 16,
    parameter int FRAC_SHIFT = 6,
    parameter int OUT_W      = 16
) (
    input logic                      ap_clk,
    input logic                      ap_rst,
    fir_hls_tap_accumulator_if.slave bus
);
    localparam int ACC_W = PROD_W + $clog2(NUM_TAPS);
    localparam int CNT_W = $clog2(NUM_TAPS);
    localparam int RES_W = ACC_W + 1 - FRAC_SHIFT;

    typedef enum logic {IDLE, ACC} state_e;

    state_e                   state_q;
    logic [CNT_W-1:0]         tapCnt_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     outValid_q;
    logic signed [OUT_W-1:0]  outData_q;
    logic                     errLast_q;

    logic                     accept;
    logic                     tapIsLast;
    logic signed [ACC_W-1:0]  prodExt;
    logic signed [ACC_W-1:0]  accSum_d;
    logic signed [ACC_W:0]    rounded;
    logic signed [RES_W-1:0]  resWide;
    logic signed [OUT_W-1:0]  outData_d;

    assign bus.in_ready  = ~outValid_q | bus.out_ready;
    assign bus.out_valid = outValid_q;
    assign bus.out_data  = outData_q;
    assign bus.err_last  = errLast_q;

    assign accept    = bus.in_valid & bus.in_ready;
    assign tapIsLast = (tapCnt_q == CNT_W'(NUM_TAPS - 1));
    assign prodExt   = {{(ACC_W-PROD_W){bus.in_data[PROD_W-1]}}, bus.in_data};
    assign accSum_d  = acc_q + prodExt;

    // One extra bit of headroom so adding the rounding constant can never wrap.
    assign rounded = {accSum_d[ACC_W-1], accSum_d} + (ACC_W+1)'(2 ** (FRAC_SHIFT - 1));
    assign resWide = rounded[ACC_W:FRAC_SHIFT];

`ifdef FIR_HLS_ACC_SATURATE_EN
    localparam logic signed [RES_W-1:0] SAT_MAX = RES_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [RES_W-1:0] SAT_MIN = ~SAT_MAX;

    logic unusedRoundBits;
    assign unusedRoundBits = ^rounded[FRAC_SHIFT-1:0];

    always_comb begin
        outData_d = resWide[OUT_W-1:0];
        if (resWide > SAT_MAX) begin
            outData_d = SAT_MAX[OUT_W-1:0];
        end else if (resWide < SAT_MIN) begin
            outData_d = SAT_MIN[OUT_W-1:0];
        end
    end
`else
    logic unusedRoundBits;
    assign unusedRoundBits = ^{rounded[FRAC_SHIFT-1:0], resWide[RES_W-1:OUT_W]};

    always_comb begin
        outData_d = resWide[OUT_W-1:0];
    end
`endif

    // Framing is owned by tapCnt_q; in_last is only compared against it.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q    <= IDLE;
            tapCnt_q   <= '0;
            acc_q      <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            errLast_q  <= 1'b0;
        end else begin
            if (outValid_q && bus.out_ready) begin
                outValid_q <= 1'b0;
            end
            if (accept) begin
                if (bus.in_last != tapIsLast) begin
                    errLast_q <= 1'b1;
                end
                case (state_q)
                    IDLE: begin
                        acc_q    <= prodExt;
                        tapCnt_q <= CNT_W'(1);
                        state_q  <= ACC;
                    end
                    ACC: begin
                        if (tapIsLast) begin
                            outValid_q <= 1'b1;
                            outData_q  <= outData_d;
                            acc_q      <= '0;
                            tapCnt_q   <= '0;
                            state_q    <= IDLE;
                        end else begin
                            acc_q    <= accSum_d;
                            tapCnt_q <= tapCnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fir_hls_tap_accumulator.sv
// Directed bench for fir_hls_tap_accumulator with NUM_TAPS=4, FRAC_SHIFT=6, OUT_W=16.
module tb_fir_hls_tap_accumulator;
    localparam int PROD_W = 23;
    localparam int OUT_W  = 16;

    logic clk;
    logic rst;
    int   totalCnt;
    int   passCnt;

    fir_hls_tap_accumulator_if #(.PROD_W(PROD_W), .OUT_W(OUT_W)) bus ();

    fir_hls_tap_accumulator #(
        .PROD_W    (PROD_W),
        .NUM_TAPS  (4),
        .FRAC_SHIFT(6),
        .OUT_W     (OUT_W)
    ) dut (
        .ap_clk(clk),
        .ap_rst(rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Presents one product and returns #1 after the edge that accepted it.
    task automatic applyStimulus(input int data, input logic last);
        logic done;
        done = 1'b0;
        bus.in_data  = PROD_W'(data);
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        checkOutput("accept_in_time", done, 1);
    endtask

    task automatic sendFrame(input int a, input int b, input int c, input int d);
        applyStimulus(a, 1'b0);
        applyStimulus(b, 1'b0);
        applyStimulus(c, 1'b0);
        applyStimulus(d, 1'b1);
    endtask

    initial begin
        int expHi;
        int expLo;
        totalCnt      = 0;
        passCnt       = 0;
        rst           = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        @(negedge clk);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_data", bus.out_data, 0);
        checkOutput("rst_err_last", bus.err_last, 0);
        checkOutput("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] basic 64 x4");
        applyStimulus(64, 1'b0);
        applyStimulus(64, 1'b0);
        applyStimulus(64, 1'b0);
        checkOutput("basic_not_early", bus.out_valid, 0);
        applyStimulus(64, 1'b1);
        checkOutput("basic_valid", bus.out_valid, 1);
        checkOutput("basic_data", bus.out_data, 4);
        checkOutput("basic_err", bus.err_last, 0);
        @(posedge clk);
        #1;
        checkOutput("basic_drained", bus.out_valid, 0);

        $display("[TB] rounding");
        sendFrame(-100, -100, -100, -100);
        checkOutput("neg_valid", bus.out_valid, 1);
        checkOutput("neg_data", bus.out_data, -6);
        sendFrame(16, 16, 0, 0);
        checkOutput("tie_data", bus.out_data, 1);

        $display("[TB] overflow");
`ifdef FIR_HLS_ACC_SATURATE_EN
        expHi = 32767;
        expLo = -32768;
`else
        expHi = 0;
        expLo = 0;
`endif
        sendFrame(4194303, 4194303, 4194303, 4194303);
        checkOutput("ovf_pos", bus.out_data, expHi);
        sendFrame(-4194304, -4194304, -4194304, -4194304);
        checkOutput("ovf_neg", bus.out_data, expLo);

        $display("[TB] backpressure");
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        sendFrame(64, 64, 64, 64);
        checkOutput("bp_result", bus.out_data, 4);
        bus.in_data  = PROD_W'(128);
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", bus.in_ready, 0);
            checkOutput("bp_out_data", bus.out_data, 4);
            checkOutput("bp_out_valid", bus.out_valid, 1);
        end
        #1;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("bp_handshake", bus.out_valid, 0);
        applyStimulus(128, 1'b0);
        applyStimulus(128, 1'b0);
        applyStimulus(128, 1'b1);
        checkOutput("bp_next_valid", bus.out_valid, 1);
        checkOutput("bp_next_data", bus.out_data, 8);
        checkOutput("bp_err", bus.err_last, 0);

        $display("[TB] framing error");
        applyStimulus(64, 1'b0);
        checkOutput("frm_err_clear", bus.err_last, 0);
        applyStimulus(64, 1'b1);
        checkOutput("frm_err_set", bus.err_last, 1);
        applyStimulus(64, 1'b0);
        checkOutput("frm_no_early", bus.out_valid, 0);
        applyStimulus(64, 1'b1);
        checkOutput("frm_valid", bus.out_valid, 1);
        checkOutput("frm_data", bus.out_data, 4);
        checkOutput("frm_err_sticky", bus.err_last, 1);

        $display("[TB] reset mid-sample");
        applyStimulus(1000, 1'b0);
        applyStimulus(1000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_err", bus.err_last, 0);
        checkOutput("mid_rst_valid", bus.out_valid, 0);
        checkOutput("mid_rst_data", bus.out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sendFrame(64, 64, 64, 64);
        checkOutput("post_rst_valid", bus.out_valid, 1);
        checkOutput("post_rst_data", bus.out_data, 4);
        checkOutput("post_rst_err", bus.err_last, 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
